// File: rtl/hsk_rx_port.sv
// Receiver for the processor byte-output handshake; optional HSK_RX_SYNC_EN adds a 2-flop request synchronizer.
// Latency: ack 1 edge after request (3 with sync), byte visible on dout the same edge it is accepted.
// Backpressure: ack is withheld while the FIFO is full; downstream pops on dout_valid & dout_ready.
module hsk_rx_port #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          g_clk,
    input  logic          g_clr,
    input  logic [7:0]    bus_out,
    input  logic          hsk_out,
    output logic          hsk_in,
    output logic [7:0]    dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [AW:0]   level,
    output logic [7:0]    xfer_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] LEVEL_MAX = (AW+1)'(DEPTH);

    state_t      state;
    logic        req;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        push;
    logic        pop;

`ifdef HSK_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], hsk_out};
        end
    end

    assign req = sync_q[1];
`else
    assign req = hsk_out;
`endif

    // Full uses the registered level, so a same-edge pop never frees room for a push.
    assign level      = wr_ptr - rd_ptr;
    assign full       = (level == LEVEL_MAX);
    assign dout_valid = (level != '0);
    assign dout       = mem[rd_ptr[AW-1:0]];
    assign push       = (state == IDLE) && req && !full;
    assign pop        = dout_valid && dout_ready;

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            state    <= IDLE;
            hsk_in   <= 1'b0;
            xfer_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        state    <= ACK;
                        hsk_in   <= 1'b1;
                        xfer_cnt <= xfer_cnt + 8'd1;
                    end
                end
                ACK: begin
                    if (!req) begin
                        state  <= IDLE;
                        hsk_in <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    hsk_in <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'd0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= bus_out;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hsk_rx_port.sv
// Directed bench for hsk_rx_port: handshake latency, fill/stall, push+pop, held request, async reset, counter wrap.
module tb_hsk_rx_port;

`ifdef HSK_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       g_clk;
    logic       g_clr;
    logic [7:0] bus_out;
    logic       hsk_out;
    logic       hsk_in;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [2:0] level;
    logic [7:0] xfer_cnt;

    int checks = 0;
    int passed = 0;

    hsk_rx_port #(.DEPTH(4), .AW(2)) dut (
        .g_clk      (g_clk),
        .g_clr      (g_clr),
        .bus_out    (bus_out),
        .hsk_out    (hsk_out),
        .hsk_in     (hsk_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .xfer_cnt   (xfer_cnt)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic apply_reset();
        g_clr      = 1'b1;
        hsk_out    = 1'b0;
        bus_out    = 8'h00;
        dout_ready = 1'b0;
        repeat (2) tick();
        g_clr = 1'b0;
        tick();
    endtask

    // Full four-phase handshake; latencies count edges, 50 means timed out.
    task automatic send(input logic [7:0] b, output int lat, output int fall_lat);
        bus_out = b;
        hsk_out = 1'b1;
        lat = 0;
        while (hsk_in !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        hsk_out  = 1'b0;
        fall_lat = 0;
        while (hsk_in !== 1'b0 && fall_lat < 50) begin
            tick();
            fall_lat++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (hsk_in !== 1'b0) $display("FAIL reset_hsk_in: got %b want 0", hsk_in); else passed++;
        checks++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dout_valid); else passed++;
        checks++; if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level); else passed++;
        checks++; if (xfer_cnt !== 8'd0) $display("FAIL reset_xfer_cnt: got %0d want 0", xfer_cnt); else passed++;
        checks++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout); else passed++;
    endtask

    task automatic test_single();
        int lat, fl;
        apply_reset();
        send(8'hA5, lat, fl);
        checks++; if (lat !== LAT) $display("FAIL single_ack_lat: got %0d want %0d", lat, LAT); else passed++;
        checks++; if (fl !== LAT) $display("FAIL single_fall_lat: got %0d want %0d", fl, LAT); else passed++;
        checks++; if (dout !== 8'hA5) $display("FAIL single_dout: got %h want a5", dout); else passed++;
        checks++; if (dout_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", dout_valid); else passed++;
        checks++; if (level !== 3'd1) $display("FAIL single_level: got %0d want 1", level); else passed++;
        checks++; if (xfer_cnt !== 8'd1) $display("FAIL single_xfer_cnt: got %0d want 1", xfer_cnt); else passed++;
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        checks++; if (level !== 3'd0 || dout_valid !== 1'b0) $display("FAIL single_pop: level %0d valid %b want 0 0", level, dout_valid); else passed++;
        tick();
        checks++; if (level !== 3'd0) $display("FAIL pop_empty_ignored: level %0d want 0", level); else passed++;
    endtask

    task automatic test_fill_stall();
        int lat, fl, wait_n;
        logic [7:0] exp;
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), lat, fl);
            checks++; if (lat !== LAT) $display("FAIL fill_ack_lat[%0d]: got %0d want %0d", i, lat, LAT); else passed++;
        end
        checks++; if (level !== 3'd4) $display("FAIL fill_level: got %0d want 4", level); else passed++;
        bus_out = 8'h05;
        hsk_out = 1'b1;
        repeat (5) tick();
        checks++; if (hsk_in !== 1'b0) $display("FAIL stall_hsk_in: got %b want 0", hsk_in); else passed++;
        checks++; if (xfer_cnt !== 8'd4) $display("FAIL stall_xfer_cnt: got %0d want 4", xfer_cnt); else passed++;
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        checks++; if (hsk_in !== 1'b0 || level !== 3'd3) $display("FAIL pop_no_same_edge_push: hsk_in %b level %0d want 0 3", hsk_in, level); else passed++;
        checks++; if (dout !== 8'h02) $display("FAIL stall_head: got %h want 02", dout); else passed++;
        tick();
        checks++; if (hsk_in !== 1'b1 || level !== 3'd4) $display("FAIL stall_release: hsk_in %b level %0d want 1 4", hsk_in, level); else passed++;
        checks++; if (xfer_cnt !== 8'd5) $display("FAIL stall_xfer_cnt_after: got %0d want 5", xfer_cnt); else passed++;
        hsk_out = 1'b0;
        wait_n = 0;
        while (hsk_in !== 1'b0 && wait_n < 50) begin
            tick();
            wait_n++;
        end
        checks++; if (wait_n !== LAT) $display("FAIL stall_fall_lat: got %0d want %0d", wait_n, LAT); else passed++;
        for (int i = 2; i <= 5; i++) begin
            exp = 8'(i);
            checks++; if (dout !== exp) $display("FAIL drain_order[%0d]: got %h want %h", i, dout, exp); else passed++;
            dout_ready = 1'b1;
            tick();
            dout_ready = 1'b0;
        end
        checks++; if (level !== 3'd0) $display("FAIL drain_level: got %0d want 0", level); else passed++;
    endtask

    task automatic test_push_pop();
        int lat, fl, wait_n;
        apply_reset();
        send(8'h10, lat, fl);
        send(8'h11, lat, fl);
        checks++; if (level !== 3'd2) $display("FAIL pp_pre_level: got %0d want 2", level); else passed++;
        bus_out = 8'h12;
        hsk_out = 1'b1;
        repeat (LAT - 1) tick();
        dout_ready = 1'b1;
        tick();
        checks++; if (hsk_in !== 1'b1 || level !== 3'd2) $display("FAIL pp_same_edge: hsk_in %b level %0d want 1 2", hsk_in, level); else passed++;
        checks++; if (dout !== 8'h11) $display("FAIL pp_head1: got %h want 11", dout); else passed++;
        hsk_out = 1'b0;
        tick();
        checks++; if (dout !== 8'h12 || level !== 3'd1) $display("FAIL pp_head2: dout %h level %0d want 12 1", dout, level); else passed++;
        tick();
        checks++; if (dout_valid !== 1'b0 || level !== 3'd0) $display("FAIL pp_empty: valid %b level %0d want 0 0", dout_valid, level); else passed++;
        dout_ready = 1'b0;
        wait_n = 0;
        while (hsk_in !== 1'b0 && wait_n < 50) begin
            tick();
            wait_n++;
        end
        checks++; if (hsk_in !== 1'b0 || xfer_cnt !== 8'd3) $display("FAIL pp_done: hsk_in %b xfer_cnt %0d want 0 3", hsk_in, xfer_cnt); else passed++;
    endtask

    task automatic test_held();
        apply_reset();
        bus_out = 8'h77;
        hsk_out = 1'b1;
        repeat (20) tick();
        hsk_out = 1'b0;
        repeat (LAT + 2) tick();
        checks++; if (level !== 3'd1) $display("FAIL held_level: got %0d want 1", level); else passed++;
        checks++; if (xfer_cnt !== 8'd1) $display("FAIL held_xfer_cnt: got %0d want 1", xfer_cnt); else passed++;
        checks++; if (dout !== 8'h77 || hsk_in !== 1'b0) $display("FAIL held_dout: dout %h hsk_in %b want 77 0", dout, hsk_in); else passed++;
    endtask

    task automatic test_reset_mid_ack();
        int lat, fl, wait_n;
        apply_reset();
        send(8'h31, lat, fl);
        send(8'h32, lat, fl);
        bus_out = 8'h33;
        hsk_out = 1'b1;
        wait_n  = 0;
        while (hsk_in !== 1'b1 && wait_n < 50) begin
            tick();
            wait_n++;
        end
        checks++; if (hsk_in !== 1'b1 || level !== 3'd3) $display("FAIL rst_pre: hsk_in %b level %0d want 1 3", hsk_in, level); else passed++;
        #2;
        g_clr = 1'b1;
        #1;
        checks++; if (hsk_in !== 1'b0) $display("FAIL rst_async_hsk_in: got %b want 0", hsk_in); else passed++;
        checks++; if (level !== 3'd0 || dout_valid !== 1'b0) $display("FAIL rst_async_fifo: level %0d valid %b want 0 0", level, dout_valid); else passed++;
        checks++; if (xfer_cnt !== 8'd0) $display("FAIL rst_async_xfer_cnt: got %0d want 0", xfer_cnt); else passed++;
        hsk_out = 1'b0;
        #1;
        g_clr = 1'b0;
        repeat (LAT + 1) tick();
        checks++; if (hsk_in !== 1'b0 || level !== 3'd0) $display("FAIL rst_after: hsk_in %b level %0d want 0 0", hsk_in, level); else passed++;
    endtask

    task automatic test_wrap();
        int lat, fl, bad;
        apply_reset();
        dout_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            send(8'(i), lat, fl);
            if (lat != LAT || fl != LAT) bad++;
            if (i == 254) begin
                checks++; if (xfer_cnt !== 8'd255) $display("FAIL wrap_255: got %0d want 255", xfer_cnt); else passed++;
            end
        end
        tick();
        checks++; if (bad !== 0) $display("FAIL wrap_latency: %0d bad handshakes want 0", bad); else passed++;
        checks++; if (xfer_cnt !== 8'd0) $display("FAIL wrap_xfer_cnt: got %0d want 0", xfer_cnt); else passed++;
        checks++; if (level !== 3'd0) $display("FAIL wrap_level: got %0d want 0", level); else passed++;
        dout_ready = 1'b0;
    endtask

    initial begin
        g_clr      = 1'b1;
        hsk_out    = 1'b0;
        bus_out    = 8'h00;
        dout_ready = 1'b0;
        test_reset();
        test_single();
        test_fill_stall();
        test_push_pop();
        test_held();
        test_reset_mid_ack();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hsk_rx_port.md
# hsk_rx_port

Peripheral-side receiver for the processor's byte-output handshake. It is the far end of the processor's `bus_out`/`hsk_out`/`hsk_in` interface:
- It acknowledges each byte the processor presents.
- It buffers accepted bytes in a small FIFO.
- It hands them to a downstream consumer over a valid/ready port.

It sits outside the processor, on the board-level I/O path, and applies back-pressure by withholding the acknowledge while its FIFO is full.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, FIFO pointer width; must equal log2(DEPTH).

Ports:
- g_clk  input  1  system clock; all state updates on the rising edge.
- g_clr  input  1  reset; asynchronous, active-high.
- bus_out  input  8  data byte driven by the processor; valid while hsk_out is high.
- hsk_out  input  1  processor request: high means a byte is present.
- hsk_in  output  1  acknowledge to the processor; registered.
- dout  output  8  head-of-FIFO byte.
- dout_valid  output  1  high when the FIFO is non-empty.
- dout_ready  input  1  consumer pops the head on any edge where dout_valid and dout_ready are both high.
- level  output  AW+1  number of bytes currently stored, 0..DEPTH.
- xfer_cnt  output  8  count of bytes accepted since reset.

## Operation
- Request signal: `req` is hsk_out, either taken directly or after the optional synchronizer (see Configuration).
- The four-phase handshake FSM has two states, IDLE and ACK.
  - IDLE (hsk_in = 0):
    - If `req` = 1 and the FIFO is not full: write bus_out into the FIFO, increment xfer_cnt, and go to ACK.
    - If `req` = 1 and the FIFO is full: stay in IDLE and capture nothing (stall).
  - ACK (hsk_in = 1): stay until `req` = 0, then return to IDLE.
  - hsk_in is asserted exactly when the state is ACK.
- Exactly one byte is written per request, however long hsk_out stays high.
- FIFO behaviour:
  - Circular buffer with write and read pointers, each AW+1 bits; the MSB distinguishes full from empty.
  - Full means level == DEPTH; empty means level == 0.
  - dout = mem[rd_ptr[AW-1:0]]. dout is don't-care while dout_valid = 0.
  - A pop while empty is ignored.
- Simultaneous push and pop:
  - Both are performed and level is unchanged.
  - The full test for a push uses the registered level at that edge. A pop on the same edge does NOT enable a push while full; the push waits one cycle.
- xfer_cnt is 8-bit and wraps 255 → 0. It is unaffected by pops.
- Reset mid-handshake:
  - State returns to IDLE, hsk_in = 0, the FIFO empties and xfer_cnt = 0.
  - If hsk_out is still high after reset is released, that is a new request and the byte is captured again. The processor side is responsible for not holding a request across reset.

## Timing
- Reset values: hsk_in = 0, dout_valid = 0, level = 0, xfer_cnt = 0, dout = 0 (FIFO storage cleared), FSM = IDLE.
- Without the synchronizer:
  - hsk_out is sampled high at edge k → byte written and hsk_in = 1 after edge k.
  - dout_valid = 1 after edge k if the FIFO was empty.
- hsk_out sampled low at edge m while in ACK → hsk_in = 0 after edge m.
- The next request can be accepted at edge m+1 at the earliest.
- Pop latency: the pop happens at the edge where both valid and ready are high. The new head appears on dout after that edge.
- Back-pressure: hsk_in rises only once the FIFO is not full; there is no timeout.

## Configuration
- HSK_RX_SYNC_EN:
  - Defined: hsk_out passes through a two-flop synchronizer (reset to 0) before reaching the FSM. Acknowledge latency grows by 2 cycles. bus_out is captured at the same edge the synchronized `req` is seen, and is treated as stable because the handshake guarantees it.
  - Undefined: hsk_out drives the FSM directly, for a same-clock processor.

## Test plan
- Single byte:
  - Stimulus: bus_out = 8'hA5, hsk_out raised and held until hsk_in = 1, then dropped; dout_ready = 0.
  - Required: hsk_in rises one edge after the request, and falls one edge after hsk_out falls; dout = A5, dout_valid = 1, level = 1, xfer_cnt = 1.
- Fill and stall:
  - Stimulus: five back-to-back handshakes (01..05) with DEPTH = 4 and dout_ready = 0.
  - Required: four are acked and level = 4. The fifth request leaves hsk_in = 0.
  - Then assert dout_ready for one cycle. Required: 01 is popped, the fifth request is acked, and the FIFO holds 02..05.
- Simultaneous push and pop:
  - Stimulus: level = 2 with dout_ready = 1 held, and a new request arrives.
  - Required: level stays at 2 and bytes emerge in order.
- Held request:
  - Stimulus: hsk_out held high for 20 cycles.
  - Required: exactly one byte written and xfer_cnt increments by 1.
- Reset mid-ACK:
  - Stimulus: assert g_clr asynchronously while hsk_in = 1 and level = 3.
  - Required: immediately hsk_in = 0, level = 0, dout_valid = 0 and xfer_cnt = 0, with no clock edge needed.
- Counter wrap:
  - Stimulus: 256 handshakes with dout_ready = 1.
  - Required: xfer_cnt = 0 and level = 0 at the end.
  - Rerun with HSK_RX_SYNC_EN defined. Required: ack latency = 3 edges after the request.
